// File: rtl/timer_bank_pkg.sv
// Shared types and defaults for the timer bank.
package timer_bank_pkg;

  typedef enum logic [1:0] {
    MODE_UP_WRAP    = 2'b00,
    MODE_UP_SAT     = 2'b01,
    MODE_DN_ONESHOT = 2'b10,
    MODE_DN_RELOAD  = 2'b11
  } mode_e;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned TICK_HZ = 2000;

  // Prescaler divide ratio that turns clk_hz into a tick_hz strobe.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, reload register, terminal-count and busy logic.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  mode_e            mode_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] count_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] Max = '1;
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] count_d, count_q;
  logic [WIDTH-1:0] reload_d, reload_q;
  logic             done_d, done_q;

  // Next state: clear beats load beats step; done only ever comes from a step.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d  = load_val_i;
      reload_d = load_val_i;
    end else if (step_i) begin
      unique case (mode_i)
        MODE_UP_WRAP: begin
          count_d = count_q + 1'b1;
          done_d  = (count_q == Max);
        end
        MODE_UP_SAT: begin
          if (count_q != Max) begin
            count_d = count_q + 1'b1;
            done_d  = (count_q == Max - 1'b1);
          end
        end
        MODE_DN_ONESHOT: begin
          if (count_q != '0) begin
            count_d = count_q - 1'b1;
            done_d  = (count_q == One);
          end
        end
        MODE_DN_RELOAD: begin
          if (count_q == One) begin
            count_d = reload_q;
            done_d  = 1'b1;
          end else if (count_q == '0) begin
            // Parked at zero: restart silently from the reload value.
            count_d = reload_q;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Counter, reload and done registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Busy: down modes while nonzero; up modes while enabled and not pinned at MAX.
  always_comb begin
    busy_o = 1'b0;
    unique case (mode_i)
      MODE_UP_WRAP:                   busy_o = enable_i;
      MODE_UP_SAT:                    busy_o = enable_i && (count_q != Max);
      MODE_DN_ONESHOT, MODE_DN_RELOAD: busy_o = (count_q != '0);
      default:                        busy_o = 1'b0;
    endcase
  end

  assign count_o = count_q;
  assign done_o  = done_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH independent timers sharing one prescaler tick.
// Optional snapshot port set enabled by defining TIMER_BANK_SNAPSHOT_EN.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV    = calc_div(CLK_HZ, TICK_HZ)
) (
  input  logic                    clk_50M,
  input  logic                    i_Reset,
  input  logic [NUM_CH-1:0]       i_Enable,
  input  logic [NUM_CH-1:0]       i_Clear,
  input  logic [NUM_CH-1:0]       i_Load,
  input  logic [NUM_CH*WIDTH-1:0] i_LoadVal,
  input  logic [NUM_CH*2-1:0]     i_Mode,
  input  logic [NUM_CH-1:0]       i_TickSel,
  output logic [NUM_CH*WIDTH-1:0] o_Count,
  output logic [NUM_CH-1:0]       o_Done,
  output logic [NUM_CH-1:0]       o_Busy,
  output logic                    o_Tick
`ifdef TIMER_BANK_SNAPSHOT_EN
  ,
  input  logic                    i_Snap,
  output logic [NUM_CH*WIDTH-1:0] o_SnapCount
`endif
);

  localparam int unsigned PreW = $clog2(DIV);
  localparam logic [PreW-1:0] PreLast = PreW'(DIV - 1);

  logic [PreW-1:0] presc_d, presc_q;

  // Free-running prescaler, wraps at DIV-1.
  always_comb begin
    presc_d = (presc_q == PreLast) ? '0 : presc_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk_50M or posedge i_Reset) begin
    if (i_Reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign o_Tick = (presc_q == PreLast);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic step;
    assign step = i_Enable[k] & (i_TickSel[k] ? o_Tick : 1'b1);

    timer_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk_i      (clk_50M),
      .rst_i      (i_Reset),
      .enable_i   (i_Enable[k]),
      .clear_i    (i_Clear[k]),
      .load_i     (i_Load[k]),
      .load_val_i (i_LoadVal[k*WIDTH +: WIDTH]),
      .mode_i     (mode_e'(i_Mode[2*k +: 2])),
      .step_i     (step),
      .count_o    (o_Count[k*WIDTH +: WIDTH]),
      .done_o     (o_Done[k]),
      .busy_o     (o_Busy[k])
    );
  end

`ifdef TIMER_BANK_SNAPSHOT_EN
  logic [NUM_CH*WIDTH-1:0] snap_d, snap_q;

  // Capture all counts atomically when requested, hold otherwise.
  always_comb begin
    snap_d = i_Snap ? o_Count : snap_q;
  end

  // Snapshot register.
  always_ff @(posedge clk_50M or posedge i_Reset) begin
    if (i_Reset) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign o_SnapCount = snap_q;
`endif

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank (WIDTH=4, NUM_CH=2, DIV=4).
module tb_timer_bank;

  localparam int unsigned W = 4;
  localparam int unsigned N = 2;
  localparam int unsigned D = 4;

  logic           clk_50M = 1'b0;
  logic           i_Reset;
  logic [N-1:0]   i_Enable, i_Clear, i_Load, i_TickSel;
  logic [N*W-1:0] i_LoadVal;
  logic [2*N-1:0] i_Mode;
  logic [N*W-1:0] o_Count;
  logic [N-1:0]   o_Done, o_Busy;
  logic           o_Tick;

  int vectors = 0;
  int miscompares = 0;
  int presc_m = 0;
  bit prev_tick = 1'b0;

  timer_bank #(
    .WIDTH  (W),
    .NUM_CH (N),
    .DIV    (D)
  ) dut (
    .clk_50M   (clk_50M),
    .i_Reset   (i_Reset),
    .i_Enable  (i_Enable),
    .i_Clear   (i_Clear),
    .i_Load    (i_Load),
    .i_LoadVal (i_LoadVal),
    .i_Mode    (i_Mode),
    .i_TickSel (i_TickSel),
    .o_Count   (o_Count),
    .o_Done    (o_Done),
    .o_Busy    (o_Busy),
    .o_Tick    (o_Tick)
  );

  always #10 clk_50M = ~clk_50M;

  // One rising edge; prev_tick records whether the tick was high before it.
  task automatic tick();
    @(posedge clk_50M);
    prev_tick = (presc_m == D - 1);
    presc_m   = (presc_m + 1) % D;
    #1;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_Enable = '0; i_Clear = '0; i_Load = '0;
    i_LoadVal = '0; i_Mode = '0; i_TickSel = '0;
    repeat (2) @(posedge clk_50M);
    #1;
    vectors++;
    if (o_Count !== '0 || o_Tick !== 1'b0 || o_Done !== '0) begin
      $display("FAIL reset_state: count=%h tick=%b done=%b want 0/0/0", o_Count, o_Tick, o_Done);
      miscompares++;
    end
    #5 i_Reset = 1'b0; presc_m = 0;
    i_Enable = 2'b01;
    repeat (7) tick();
    vectors++;
    if (o_Count[3:0] !== 4'd7) begin
      $display("FAIL pre_reset_count: got %0d want 7", o_Count[3:0]);
      miscompares++;
    end
    #3 i_Reset = 1'b1; i_Enable = '0;
    #1;
    vectors++;
    if (o_Count !== '0 || o_Done !== '0) begin
      $display("FAIL async_reset: count=%h done=%b want 0/0", o_Count, o_Done);
      miscompares++;
    end
    #3 i_Reset = 1'b0; presc_m = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vectors++;
      if (o_Tick !== ((k % 4) == 3)) begin
        $display("FAIL tick_cycle%0d: got %b want %b", k + 1, o_Tick, (k % 4) == 3);
        miscompares++;
      end
    end
  endtask

  task automatic test_up_wrap();
    i_Clear = 2'b01; tick(); i_Clear = '0;
    vectors++;
    if (o_Count[3:0] !== 4'd0) begin
      $display("FAIL wrap_clear: got %0d want 0", o_Count[3:0]);
      miscompares++;
    end
    i_Mode[1:0] = 2'b00; i_TickSel = '0; i_Enable = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      tick();
      vectors++;
      if (o_Count[3:0] !== 4'(k % 16) || o_Done[0] !== (k == 16)) begin
        $display("FAIL up_wrap_step%0d: count=%0d done=%b want %0d/%b",
                 k, o_Count[3:0], o_Done[0], k % 16, k == 16);
        miscompares++;
      end
    end
    i_Enable = '0;
  endtask

  task automatic test_up_sat();
    i_Clear = 2'b01; tick(); i_Clear = '0;
    i_Mode[1:0] = 2'b01; i_Enable = 2'b01;
    for (int k = 1; k <= 35; k++) begin
      int exp;
      exp = (k < 15) ? k : 15;
      tick();
      vectors++;
      if (o_Count[3:0] !== 4'(exp) || o_Done[0] !== (k == 15)) begin
        $display("FAIL up_sat_step%0d: count=%0d done=%b want %0d/%b",
                 k, o_Count[3:0], o_Done[0], exp, k == 15);
        miscompares++;
      end
      if (k == 14 || k >= 15) begin
        vectors++;
        if (o_Busy[0] !== (k == 14)) begin
          $display("FAIL up_sat_busy%0d: got %b want %b", k, o_Busy[0], k == 14);
          miscompares++;
        end
      end
    end
    i_Enable = '0;
  endtask

  task automatic test_down_reload();
    int cnt, rel;
    bit dm;
    i_Mode[3:2] = 2'b11; i_LoadVal[7:4] = 4'd3; i_Load = 2'b10;
    tick(); i_Load = '0;
    cnt = 3; rel = 3;
    vectors++;
    if (o_Count[7:4] !== 4'd3) begin
      $display("FAIL reload_load: got %0d want 3", o_Count[7:4]);
      miscompares++;
    end
    i_TickSel = 2'b10; i_Enable = 2'b10;
    for (int k = 1; k <= 26; k++) begin
      tick();
      dm = 1'b0;
      if (prev_tick) begin
        if (cnt == 1) begin
          cnt = rel; dm = 1'b1;
        end else if (cnt == 0) begin
          cnt = rel;
        end else begin
          cnt--;
        end
      end
      vectors++;
      if (o_Count[7:4] !== 4'(cnt) || o_Done[1] !== dm || o_Tick !== (presc_m == D - 1)) begin
        $display("FAIL dn_reload_cyc%0d: count=%0d done=%b tick=%b want %0d/%b/%b",
                 k, o_Count[7:4], o_Done[1], o_Tick, cnt, dm, presc_m == D - 1);
        miscompares++;
      end
    end
    i_Enable = '0; i_TickSel = '0;
  endtask

  task automatic test_priority();
    // ch0 sits at 15 in wrap mode, so an unmasked step would pulse done.
    i_Mode[1:0] = 2'b00; i_LoadVal[3:0] = 4'd9;
    i_Enable = 2'b01; i_Clear = 2'b01; i_Load = 2'b01;
    tick();
    vectors++;
    if (o_Count[3:0] !== 4'd0 || o_Done[0] !== 1'b0) begin
      $display("FAIL prio_clear: count=%0d done=%b want 0/0", o_Count[3:0], o_Done[0]);
      miscompares++;
    end
    i_Clear = '0; i_Enable = '0;
    tick(); i_Load = '0;
    vectors++;
    if (o_Count[3:0] !== 4'd9 || o_Done[0] !== 1'b0) begin
      $display("FAIL prio_load: count=%0d done=%b want 9/0", o_Count[3:0], o_Done[0]);
      miscompares++;
    end
    i_Mode[1:0] = 2'b11; i_Enable = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      int exp;
      exp = (k < 9) ? 9 - k : 9;
      tick();
      vectors++;
      if (o_Count[3:0] !== 4'(exp) || o_Done[0] !== (k == 9)) begin
        $display("FAIL prio_reload%0d: count=%0d done=%b want %0d/%b",
                 k, o_Count[3:0], o_Done[0], exp, k == 9);
        miscompares++;
      end
    end
    i_Enable = '0; i_Clear = 2'b01; tick(); i_Clear = '0;
    i_Enable = 2'b01; tick(); i_Enable = '0;
    vectors++;
    if (o_Count[3:0] !== 4'd9 || o_Done[0] !== 1'b0) begin
      $display("FAIL clear_keeps_reload: count=%0d done=%b want 9/0", o_Count[3:0], o_Done[0]);
      miscompares++;
    end
  endtask

  task automatic test_oneshot();
    i_Mode[1:0] = 2'b10; i_LoadVal[3:0] = 4'd1; i_Load = 2'b01;
    tick(); i_Load = '0;
    vectors++;
    if (o_Count[3:0] !== 4'd1 || o_Busy[0] !== 1'b1) begin
      $display("FAIL oneshot_load: count=%0d busy=%b want 1/1", o_Count[3:0], o_Busy[0]);
      miscompares++;
    end
    i_Enable = 2'b01;
    tick();
    vectors++;
    if (o_Count[3:0] !== 4'd0 || o_Done[0] !== 1'b1 || o_Busy[0] !== 1'b0) begin
      $display("FAIL oneshot_end: count=%0d done=%b busy=%b want 0/1/0",
               o_Count[3:0], o_Done[0], o_Busy[0]);
      miscompares++;
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      vectors++;
      if (o_Count[3:0] !== 4'd0 || o_Done[0] !== 1'b0 || o_Busy[0] !== 1'b0) begin
        $display("FAIL oneshot_hold%0d: count=%0d done=%b busy=%b want 0/0/0",
                 k, o_Count[3:0], o_Done[0], o_Busy[0]);
        miscompares++;
      end
    end
    i_Enable = '0;
  endtask

  task automatic test_back_to_back();
    // Different events on both channels in the same edge.
    i_LoadVal[3:0] = 4'd5; i_Load = 2'b01; i_Clear = 2'b10;
    tick();
    i_Load = '0; i_Clear = '0;
    vectors++;
    if (o_Count[3:0] !== 4'd5 || o_Count[7:4] !== 4'd0) begin
      $display("FAIL simultaneous: ch0=%0d ch1=%0d want 5/0", o_Count[3:0], o_Count[7:4]);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_up_sat();
    test_down_reload();
    test_priority();
    test_oneshot();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised successor to the single game counter.
- NUM_CH independent counters share one clk_50M domain and one built-in prescaler. The prescaler replaces the separate 2 kHz clock with a tick strobe.
- Each channel has four modes (up-wrap, up-saturate, down-one-shot, down-auto-reload), plus synchronous clear, load and a terminal-count pulse.
- Serves the BlackJack control FSM for timeouts (e.g. the 2 s reveal delay), card-index counting and score sequencing.

Parameters:
- WIDTH, 12, bits per channel counter.
- NUM_CH, 4, number of channels (1..16).
- DIV, 25000, prescaler divide ratio; clk_50M/DIV gives a 2 kHz tick. Must be >= 2.

Ports:
- clk_50M  in  1  system clock, 50 MHz, all logic on rising edge.
- i_Reset  in  1  asynchronous, active-high reset for the whole block.
- i_Enable  in  NUM_CH  per-channel count enable.
- i_Clear  in  NUM_CH  per-channel synchronous clear to 0.
- i_Load  in  NUM_CH  per-channel synchronous load of i_LoadVal slice; also captures the reload value.
- i_LoadVal  in  NUM_CH*WIDTH  load values; channel k uses bits [k*WIDTH +: WIDTH].
- i_Mode  in  NUM_CH*2  channel k uses bits [2k+1:2k]: 00 up-wrap, 01 up-saturate, 10 down-one-shot, 11 down-reload.
- i_TickSel  in  NUM_CH  0 = step every clk_50M cycle; 1 = step only on the prescaler tick.
- o_Count  out  NUM_CH*WIDTH  registered counts, packed like i_LoadVal.
- o_Done  out  NUM_CH  one-cycle terminal-count pulse, registered.
- o_Busy  out  NUM_CH  down modes: count != 0; up modes: enabled and not saturated.
- o_Tick  out  1  one-cycle prescaler strobe.

Behaviour:
Reset:
- i_Reset high forces, asynchronously: all counts 0, all reload registers 0, prescaler 0, o_Done 0, o_Tick 0.
- Release takes effect on the next clk_50M edge.
- Reset asserted mid-count aborts without a Done pulse.

Prescaler:
- Free-running 0..DIV-1 and wraps.
- o_Tick = 1 during the cycle in which the prescaler equals DIV-1; it returns to 0 on the following edge.
- Unaffected by any channel input.

Per-channel step strobe:
- step = i_Enable & (i_TickSel ? o_Tick : 1).

Priority per edge, highest first:
1. i_Clear: count 0; reload register unchanged; no Done.
2. i_Load: count and reload register both take the i_LoadVal slice; no Done.
3. step: apply the mode rule below.
4. Otherwise hold.

Mode rules on step (MAX = 2^WIDTH-1):
- up-wrap: count+1; MAX→0 wraps and pulses Done.
- up-saturate: count+1 until MAX; the MAX-1→MAX transition pulses Done; at MAX, hold with no further pulses.
- down-one-shot: count-1; 1→0 pulses Done; at 0, hold with no pulse (underflow forbidden).
- down-reload: count-1; 1→reload pulses Done; at 0, load reload with no pulse. Reload value 0 with count 0 stays 0 and never pulses.

Timing and concurrency:
- o_Done asserts in the same cycle the new count is visible on o_Count, i.e. one edge after the step is sampled.
- A mode change takes effect on the next step and does not alter the current count.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.

Optional Feature:
- Macro: TIMER_BANK_SNAPSHOT_EN.
- Defined: adds input i_Snap (1) and output o_SnapCount (NUM_CH*WIDTH). On an edge with i_Snap=1, all o_Count values present before that edge are captured atomically into o_SnapCount; it holds otherwise and resets to 0.
- Undefined: neither port exists and no snapshot registers are built.

Decomposition:
- Package timer_bank_pkg holds:
  - the mode typedef (2-bit enum MODE_UP_WRAP, MODE_UP_SAT, MODE_DN_ONESHOT, MODE_DN_RELOAD);
  - the default constants CLK_HZ=50_000_000 and TICK_HZ=2000;
  - a function computing DIV from CLK_HZ/TICK_HZ.
- Sub-module timer_channel contains one counter, its reload register and its Done/Busy logic, and is instantiated NUM_CH times in a generate loop.
- The prescaler stays in the top level.

Test Plan (WIDTH=4, NUM_CH=2, DIV=4 unless stated):
- Reset: assert i_Reset mid-count at count=7 → o_Count=0 asynchronously. Released with no inputs → o_Tick pulses on cycles 4, 8, 12 after release.
- Up-wrap: ch0 mode 00, i_TickSel=0, enable from 0 → counts 0..15,0. o_Done high exactly in the cycle o_Count reads 0 after 15.
- Up-saturate: ch0 mode 01 → reaches 15, a single Done pulse, holds at 15 for 20 further cycles, o_Busy=0.
- Down-reload on tick: ch1 load 3, mode 11, i_TickSel=1 → decrements once per 4 cycles 3,2,1,3. Done pulses with each 1→3 transition, every 12 cycles.
- Priority: same edge i_Clear=1, i_Load=1 (LoadVal 9), step=1 → count 0, no Done. Next edge Load only → count 9, reload 9.
- Down-one-shot underflow: load 1, mode 10, enable → 0 with one Done. 10 further steps → stays 0, no Done, o_Busy=0.
